// File: rtl/spin_pkg.sv
// Shared types and the rotation address helper for the ImageSpin frame sequencer.
package spin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_e;

  localparam int unsigned COORD_MAX = 16;

  typedef struct packed {
    logic [COORD_MAX-1:0] row;
    logic [COORD_MAX-1:0] col;
  } coord_t;

  // Coordinates are zero-extended; M-x equals ~x inside the low side_log2 bits.
  function automatic coord_t rot_addr(input logic [COORD_MAX-1:0] r,
                                      input logic [COORD_MAX-1:0] c,
                                      input rot_e                 mode,
                                      input int unsigned          side_log2);
    logic [COORD_MAX-1:0] mask;
    logic [COORD_MAX-1:0] r_inv;
    logic [COORD_MAX-1:0] c_inv;
    coord_t               res;
    mask  = (COORD_MAX'(1'b1) << side_log2) - COORD_MAX'(1'b1);
    r_inv = ~r & mask;
    c_inv = ~c & mask;
    case (mode)
      ROT_0:   res = '{row: r,     col: c};
      ROT_90:  res = '{row: c,     col: r_inv};
      ROT_180: res = '{row: r_inv, col: c_inv};
      ROT_270: res = '{row: c_inv, col: r};
      default: res = '{row: r,     col: c};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spin_addr_map.sv
// Combinational map from a source (row, col) and rotation mode to the destination address.
module spin_addr_map
  import spin_pkg::*;
#(
  parameter int unsigned SIDE_LOG2 = 8
) (
  input  logic [SIDE_LOG2-1:0]   row,
  input  logic [SIDE_LOG2-1:0]   col,
  input  logic [1:0]             mode,
  output logic [2*SIDE_LOG2-1:0] addr
);

  coord_t rot_s;

  // Rotate and pack the result as {row, col}.
  always_comb begin
    rot_s = rot_addr(COORD_MAX'(row), COORD_MAX'(col), rot_e'(mode), SIDE_LOG2);
    addr  = {rot_s.row[SIDE_LOG2-1:0], rot_s.col[SIDE_LOG2-1:0]};
  end

  if (SIDE_LOG2 < COORD_MAX) begin : g_pad
    logic unused_pad_s;
    assign unused_pad_s = ^{rot_s.row[COORD_MAX-1:SIDE_LOG2], rot_s.col[COORD_MAX-1:SIDE_LOG2]};
  end

endmodule

// File: rtl/spin_ctrl.sv
// Frame rotation sequencer: raster-reads the source SRAM and writes each pixel one
// cycle later to its rotated address in the destination SRAM.
module spin_ctrl
  import spin_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SIDE_LOG2  = 8,
  parameter int unsigned ADDR_WIDTH = 2*SIDE_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  src_en,
  output logic                  src_wr,
  input  logic [DATA_WIDTH-1:0] src_rdata,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [DATA_WIDTH-1:0] dst_wdata,
  output logic                  dst_en,
  output logic                  dst_wr
);

  localparam logic [SIDE_LOG2-1:0] CNT_MAX = {SIDE_LOG2{1'b1}};

  state_e                state_q, state_d;
  logic [SIDE_LOG2-1:0]  row_q, row_d;
  logic [SIDE_LOG2-1:0]  col_q, col_d;
  logic [1:0]            mode_q, mode_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dst_en_q, dst_en_d;
  logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
  logic                  src_en_s;
  logic [ADDR_WIDTH-1:0] rot_addr_s;

  spin_addr_map #(.SIDE_LOG2(SIDE_LOG2)) u_addr_map (
    .row  (row_q),
    .col  (col_q),
    .mode (mode_q),
    .addr (rot_addr_s)
  );

  // Next-state, counter and write-pipe logic.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    mode_d   = mode_q;
    src_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          src_en_s = 1'b1;
          if (col_q == CNT_MAX) begin
            col_d = '0;
            row_d = row_q + SIDE_LOG2'(1'b1);
            if (row_q == CNT_MAX) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            col_d = col_q + SIDE_LOG2'(1'b1);
          end
        end else begin
          src_en_s = 1'b0;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    dst_en_d   = src_en_s;
    dst_addr_d = src_en_s ? rot_addr_s : dst_addr_q;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      mode_q     <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dst_en_q   <= 1'b0;
      dst_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dst_en_q   <= dst_en_d;
      dst_addr_q <= dst_addr_d;
    end
  end

  // Read data arrives in the write cycle, so it is forwarded rather than registered.
  assign src_addr  = {row_q, col_q};
  assign src_en    = src_en_s;
  assign src_wr    = 1'b0;
  assign dst_addr  = dst_addr_q;
  assign dst_wdata = dst_en_q ? src_rdata : '0;
  assign dst_en    = dst_en_q;
  assign dst_wr    = dst_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
